// File: rtl/jtcontra_pkg.sv
// jtcontra_pkg
//   Shared constants for the Contra loader: default start offsets of the
//   regions in the download image, the write-FSM state encoding, the
//   loader FIFO depth and the SDRAM request record queued by the loader.
package jtcontra_pkg;

    // Region start offsets in the byte-addressed download image
    localparam logic [24:0] SND_START_DEF  = 25'h2_0000;
    localparam logic [24:0] GFX1_START_DEF = 25'h2_8000;
    localparam logic [24:0] GFX2_START_DEF = 25'hA_8000;
    localparam logic [24:0] PROM_START_DEF = 25'h12_8000;

    // Write FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam int unsigned LOADER_FIFO_DEPTH = 4;

    // One queued SDRAM byte write
    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_req_t;

    // Active-low byte enable: odd byte address selects the upper byte
    function automatic logic [1:0] byte_mask(input logic odd);
        return odd ? 2'b01 : 2'b10;
    endfunction

endpackage

// File: rtl/jtcontra_sdram_loader_if.sv
// jtcontra_sdram_loader_if
//   Bundles the download port, the SDRAM programming port, the PROM write
//   port and the status outputs of the loader.
//   slave  : loader side (takes ioctl_* / downloading / sdram_ack, drives the rest)
//   master : host side (the opposite direction)
interface jtcontra_sdram_loader_if;

    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        sdram_ack;

    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;

    logic [3:0]  prom_we;
    logic [7:0]  prom_addr;
    logic [7:0]  prom_data;

    logic        dwnld_busy;
    logic        overflow;
    logic [15:0] checksum;

    modport slave (
        input  downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        output prog_addr, prog_data, prog_mask, prog_we,
        output prom_we, prom_addr, prom_data,
        output dwnld_busy, overflow, checksum
    );

    modport master (
        output downloading, ioctl_addr, ioctl_data, ioctl_wr, sdram_ack,
        input  prog_addr, prog_data, prog_mask, prog_we,
        input  prom_we, prom_addr, prom_data,
        input  dwnld_busy, overflow, checksum
    );

endinterface

// File: rtl/jtcontra_loader_fifo.sv
// jtcontra_loader_fifo
//   Small synchronous FIFO, first-word-fall-through (o_data shows the head).
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (ignored when full unless i_pop is also set)
//   i_pop      : retire the head (ignored when empty)
//   o_data     : current head entry
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module jtcontra_loader_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still takes a push when the head leaves on the same edge
    assign w_push_ok = i_push && (!o_full || i_pop);
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jtcontra_sdram_loader.sv
// jtcontra_sdram_loader
//   Routes the ROM download stream: bytes below PROM_START are queued and
//   written to SDRAM one at a time with a request/ack handshake; bytes in the
//   1 KiB PROM window become one-cycle strobes on one of four PROMs; bytes
//   above it are dropped. Keeps a running checksum and a sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : download input, SDRAM programming port, PROM port, status
module jtcontra_sdram_loader
    import jtcontra_pkg::*;
#(
    parameter logic [24:0] SND_START  = SND_START_DEF,
    parameter logic [24:0] GFX1_START = GFX1_START_DEF,
    parameter logic [24:0] GFX2_START = GFX2_START_DEF,
    parameter logic [24:0] PROM_START = PROM_START_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    jtcontra_sdram_loader_if.slave   bus
);

    localparam logic [24:0] PROM_LAST = PROM_START + 25'd1023;

    // Word-address view of the region starts
    localparam logic [21:0] SND_W  = SND_START[22:1];
    localparam logic [21:0] GFX1_W = GFX1_START[22:1];
    localparam logic [21:0] GFX2_W = GFX2_START[22:1];

    // Each region is rebased onto the end of the one before it, main ROM
    // filling words [0, SND_W). The regions abut in the download image, so
    // this packing folds to the plain word address.
    localparam logic [21:0] SND_BASE_W  = SND_W;
    localparam logic [21:0] GFX1_BASE_W = SND_BASE_W + (GFX1_W - SND_W);
    localparam logic [21:0] GFX2_BASE_W = GFX1_BASE_W + (GFX2_W - GFX1_W);

    logic [0:0]  r_state;
    logic [21:0] r_prog_addr;
    logic [7:0]  r_prog_data;
    logic [1:0]  r_prog_mask;
    logic        r_prog_we;
    logic [3:0]  r_prom_we;
    logic [7:0]  r_prom_addr;
    logic [7:0]  r_prom_data;
    logic        r_overflow;
    logic [15:0] r_checksum;
    logic        r_dl_q;

    logic        w_accept;
    logic        w_is_sdram;
    logic        w_is_prom;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic        w_pop;
    logic        w_stored;
    logic [21:0] w_prog_word;
    prog_req_t   w_req;
    prog_req_t   w_head;

    assign w_accept   = bus.ioctl_wr && bus.downloading;
    assign w_is_sdram = w_accept && (bus.ioctl_addr < PROM_START);
    assign w_is_prom  = w_accept && (bus.ioctl_addr >= PROM_START)
                                 && (bus.ioctl_addr <= PROM_LAST);

    always_comb begin
        w_prog_word = bus.ioctl_addr[22:1];
        if (bus.ioctl_addr >= GFX2_START) begin
            w_prog_word = bus.ioctl_addr[22:1] - GFX2_W + GFX2_BASE_W;
        end else if (bus.ioctl_addr >= GFX1_START) begin
            w_prog_word = bus.ioctl_addr[22:1] - GFX1_W + GFX1_BASE_W;
        end else if (bus.ioctl_addr >= SND_START) begin
            w_prog_word = bus.ioctl_addr[22:1] - SND_W + SND_BASE_W;
        end
    end

    assign w_req.addr = w_prog_word;
    assign w_req.data = bus.ioctl_data;
    assign w_req.mask = byte_mask(bus.ioctl_addr[0]);

    // The head stays queued while its write is in flight and is retired on
    // the ack, so the in-flight byte occupies one of the FIFO slots.
    assign w_pop = (r_state == ST_WAIT) && bus.sdram_ack;

    // Byte actually landed somewhere (queued or sent to a PROM)
    assign w_stored = (w_is_sdram && (!w_fifo_full || w_pop)) || w_is_prom;

    jtcontra_loader_fifo #(
        .DEPTH (LOADER_FIFO_DEPTH),
        .WIDTH ($bits(prog_req_t))
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_is_sdram),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // SDRAM write FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_mask <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_prog_addr <= w_head.addr;
                        r_prog_data <= w_head.data;
                        r_prog_mask <= w_head.mask;
                        r_prog_we   <= 1'b1;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.sdram_ack) begin
                        r_prog_we <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_prog_we <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // PROM strobes, one cycle behind the download strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prom_we   <= '0;
            r_prom_addr <= '0;
            r_prom_data <= '0;
        end else begin
            r_prom_we <= '0;
            if (w_is_prom) begin
                r_prom_we   <= 4'b0001 << bus.ioctl_addr[9:8];
                r_prom_addr <= bus.ioctl_addr[7:0];
                r_prom_data <= bus.ioctl_data;
            end
        end
    end

    // Overflow flag and checksum
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_checksum <= '0;
            r_dl_q     <= 1'b0;
        end else begin
            r_dl_q <= bus.downloading;
            if (w_is_sdram && w_fifo_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (bus.downloading && !r_dl_q) begin
                r_checksum <= w_stored ? 16'(bus.ioctl_data) : '0;
            end else if (w_stored) begin
                r_checksum <= r_checksum + 16'(bus.ioctl_data);
            end
        end
    end

    assign bus.prog_addr  = r_prog_addr;
    assign bus.prog_data  = r_prog_data;
    assign bus.prog_mask  = r_prog_mask;
    assign bus.prog_we    = r_prog_we;
    assign bus.prom_we    = r_prom_we;
    assign bus.prom_addr  = r_prom_addr;
    assign bus.prom_data  = r_prom_data;
    assign bus.overflow   = r_overflow;
    assign bus.checksum   = r_checksum;
    assign bus.dwnld_busy = bus.downloading || !w_fifo_empty || (r_state == ST_WAIT);

endmodule

// File: tb/tb_jtcontra_sdram_loader.sv
// tb_jtcontra_sdram_loader
//   Directed bench for the Contra download loader: a table of single-byte
//   writes with hand-computed routing results, followed by hand-written
//   sequences for checksum, overflow, drain-after-download and reset-in-WAIT.
module tb_jtcontra_sdram_loader;

    localparam int K_SDRAM = 0;
    localparam int K_PROM  = 1;
    localparam int K_DROP  = 2;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
        int          kind;
        logic [21:0] pa;
        logic [1:0]  mask;
        logic [3:0]  prom;
        logic [7:0]  paddr;
        int          hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    jtcontra_sdram_loader_if bus();

    jtcontra_sdram_loader #(
        .SND_START  (25'h2_0000),
        .GFX1_START (25'h2_8000),
        .GFX2_START (25'hA_8000),
        .PROM_START (25'h12_8000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // n consecutive one-cycle strobes with incrementing address and data
    task automatic burst(input logic [24:0] a0, input logic [7:0] d0, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bus.ioctl_addr = a0 + 25'(k);
            bus.ioctl_data = d0 + 8'(k);
            bus.ioctl_wr   = 1'b1;
        end
        @(negedge clk);
        bus.ioctl_wr = 1'b0;
    endtask

    // Wait for a request, check it, hold it for 'hold' sampled cycles, ack it
    task automatic serve(input string nm, input int hold,
                         input logic [21:0] pa, input logic [7:0] d, input logic [1:0] m);
        int waited;
        waited = 0;
        while (bus.prog_we !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_req"}, 64'(bus.prog_we), 64'(1));
        if (bus.prog_we === 1'b1) begin
            check({nm, "_addr"}, 64'(bus.prog_addr), 64'(pa));
            check({nm, "_data"}, 64'(bus.prog_data), 64'(d));
            check({nm, "_mask"}, 64'(bus.prog_mask), 64'(m));
            for (int k = 1; k < hold; k++) begin
                @(negedge clk);
                check({nm, "_hold"},
                      64'({bus.prog_we, bus.prog_addr, bus.prog_data, bus.prog_mask}),
                      64'({1'b1, pa, d, m}));
            end
            bus.sdram_ack = 1'b1;
            @(negedge clk);
            bus.sdram_ack = 1'b0;
            check({nm, "_release"}, 64'(bus.prog_we), 64'(0));
        end
    endtask

    // No SDRAM request or PROM strobe now nor over the next n cycles
    task automatic quiet(input string nm, input int n);
        logic seen;
        seen = bus.prog_we | (|bus.prom_we);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            seen = seen | bus.prog_we | (|bus.prom_we);
        end
        check({nm, "_quiet"}, 64'(seen), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [11];
        logic [15:0] sum;

        tbl[0]  = '{25'h000_0003, 8'h5A, K_SDRAM, 22'h00_0001, 2'b01, 4'b0000, 8'h00, 3};
        tbl[1]  = '{25'h000_0000, 8'h11, K_SDRAM, 22'h00_0000, 2'b10, 4'b0000, 8'h00, 1};
        tbl[2]  = '{25'h002_0004, 8'h22, K_SDRAM, 22'h01_0002, 2'b10, 4'b0000, 8'h00, 2};
        tbl[3]  = '{25'h002_8001, 8'h33, K_SDRAM, 22'h01_4000, 2'b01, 4'b0000, 8'h00, 1};
        tbl[4]  = '{25'h00A_8007, 8'h44, K_SDRAM, 22'h05_4003, 2'b01, 4'b0000, 8'h00, 1};
        tbl[5]  = '{25'h012_7FFF, 8'h55, K_SDRAM, 22'h09_3FFF, 2'b01, 4'b0000, 8'h00, 1};
        tbl[6]  = '{25'h012_8105, 8'h77, K_PROM,  22'h00_0000, 2'b00, 4'b0010, 8'h05, 0};
        tbl[7]  = '{25'h012_8000, 8'h88, K_PROM,  22'h00_0000, 2'b00, 4'b0001, 8'h00, 0};
        tbl[8]  = '{25'h012_83FF, 8'h99, K_PROM,  22'h00_0000, 2'b00, 4'b1000, 8'hFF, 0};
        tbl[9]  = '{25'h012_8400, 8'hAA, K_DROP,  22'h00_0000, 2'b00, 4'b0000, 8'h00, 0};
        tbl[10] = '{25'h1FF_FFFF, 8'hBB, K_DROP,  22'h00_0000, 2'b00, 4'b0000, 8'h00, 0};

        rst_n           = 1'b0;
        bus.downloading = 1'b0;
        bus.ioctl_addr  = '0;
        bus.ioctl_data  = '0;
        bus.ioctl_wr    = 1'b0;
        bus.sdram_ack   = 1'b0;

        // Reset state
        #12;
        check("rst_prog_we",   64'(bus.prog_we),    64'(0));
        check("rst_prom_we",   64'(bus.prom_we),    64'(0));
        check("rst_overflow",  64'(bus.overflow),   64'(0));
        check("rst_checksum",  64'(bus.checksum),   64'(0));
        check("rst_busy",      64'(bus.dwnld_busy), 64'(0));
        check("rst_prog_addr", 64'(bus.prog_addr),  64'(0));
        check("rst_prog_data", 64'(bus.prog_data),  64'(0));
        check("rst_prog_mask", 64'(bus.prog_mask),  64'(2'b11));
        check("rst_prom_addr", 64'(bus.prom_addr),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.downloading = 1'b1;
        @(negedge clk);

        // Table of single-byte routing vectors
        sum = 16'h0000;
        for (int i = 0; i < 11; i++) begin
            burst(tbl[i].addr, tbl[i].data, 1);
            if (tbl[i].kind == K_SDRAM) begin
                sum = sum + 16'(tbl[i].data);
                serve($sformatf("v%0d", i), tbl[i].hold, tbl[i].pa, tbl[i].data, tbl[i].mask);
            end else if (tbl[i].kind == K_PROM) begin
                sum = sum + 16'(tbl[i].data);
                check($sformatf("v%0d_prom_we", i),   64'(bus.prom_we),   64'(tbl[i].prom));
                check($sformatf("v%0d_prom_addr", i), 64'(bus.prom_addr), 64'(tbl[i].paddr));
                check($sformatf("v%0d_prom_data", i), 64'(bus.prom_data), 64'(tbl[i].data));
                check($sformatf("v%0d_no_prog", i),   64'(bus.prog_we),   64'(0));
                @(negedge clk);
                check($sformatf("v%0d_prom_pulse", i), 64'({bus.prom_we, bus.prog_we}), 64'(0));
            end else begin
                quiet($sformatf("v%0d", i), 4);
            end
        end
        check("table_checksum", 64'(bus.checksum), 64'(sum));
        check("table_no_overflow", 64'(bus.overflow), 64'(0));

        // Checksum: clear on rising downloading, wrap-free sum, ignored strobes
        bus.downloading = 1'b0;
        @(negedge clk);
        bus.downloading = 1'b1;
        @(negedge clk);
        check("cks_clear", 64'(bus.checksum), 64'(0));
        burst(25'h012_8000, 8'hFF, 1);
        burst(25'h012_8001, 8'h02, 1);
        @(negedge clk);
        check("cks_sum", 64'(bus.checksum), 64'(16'h0101));
        bus.downloading = 1'b0;
        @(negedge clk);
        burst(25'h012_8010, 8'h40, 1);
        quiet("ign_prom", 2);
        burst(25'h000_0010, 8'h41, 1);
        quiet("ign_sdram", 4);
        check("ign_checksum", 64'(bus.checksum), 64'(16'h0101));
        bus.downloading = 1'b1;
        @(negedge clk);
        check("cks_reclear", 64'(bus.checksum), 64'(0));

        // Overflow: ack held low, five bytes, four survive
        burst(25'h000_0040, 8'hC0, 5);
        check("ovf_flag", 64'(bus.overflow), 64'(1));
        bus.downloading = 1'b0;
        serve("ovf0", 1, 22'h20, 8'hC0, 2'b10);
        @(negedge clk);
        check("ovf_spacing1", 64'(bus.prog_we), 64'(1));
        serve("ovf1", 1, 22'h20, 8'hC1, 2'b01);
        @(negedge clk);
        check("ovf_spacing2", 64'(bus.prog_we), 64'(1));
        serve("ovf2", 1, 22'h21, 8'hC2, 2'b10);
        @(negedge clk);
        check("ovf_spacing3", 64'(bus.prog_we), 64'(1));
        serve("ovf3", 1, 22'h21, 8'hC3, 2'b01);
        check("ovf_busy_low", 64'(bus.dwnld_busy), 64'(0));
        quiet("ovf_drop", 6);
        check("ovf_sticky", 64'(bus.overflow), 64'(1));

        // Downloading falls with three bytes queued
        bus.downloading = 1'b1;
        burst(25'h002_0010, 8'h31, 3);
        bus.downloading = 1'b0;
        #1;
        check("drain_busy0", 64'(bus.dwnld_busy), 64'(1));
        serve("drain0", 2, 22'h01_0008, 8'h31, 2'b10);
        check("drain_busy1", 64'(bus.dwnld_busy), 64'(1));
        serve("drain1", 1, 22'h01_0008, 8'h32, 2'b01);
        check("drain_busy2", 64'(bus.dwnld_busy), 64'(1));
        serve("drain2", 1, 22'h01_0009, 8'h33, 2'b10);
        check("drain_busy_end", 64'(bus.dwnld_busy), 64'(0));
        quiet("drain_after", 4);

        // Reset asserted while a write is waiting for its ack
        bus.downloading = 1'b1;
        burst(25'h000_0100, 8'hE1, 1);
        bus.downloading = 1'b0;
        for (int k = 0; k < 20 && bus.prog_we !== 1'b1; k++) begin
            @(negedge clk);
        end
        check("rstw_in_wait", 64'(bus.prog_we), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rstw_prog_we",  64'(bus.prog_we),    64'(0));
        check("rstw_busy",     64'(bus.dwnld_busy), 64'(0));
        check("rstw_overflow", 64'(bus.overflow),   64'(0));
        check("rstw_mask",     64'(bus.prog_mask),  64'(2'b11));
        @(negedge clk);
        rst_n = 1'b1;
        quiet("rstw_after", 8);
        check("rstw_busy_after", 64'(bus.dwnld_busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/jtcontra_sdram_loader.md
JTCONTRA_SDRAM_LOADER -- requirements
Module: jtcontra_sdram_loader

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- SND_START, 25'h2_0000, first byte of sound ROM
- GFX1_START, 25'h2_8000, first byte of GFX1
- GFX2_START, 25'hA_8000, first byte of GFX2
- PROM_START, 25'h12_8000, first byte of the PROM area, 4x256 B
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, system clock; the block has one clock, and the reset is asynchronous and active-low
- rst_n, in, 1, asynchronous active-low reset
- downloading, in, 1, download window active
- ioctl_addr, in, 25, byte address
- ioctl_data, in, 8, byte
- ioctl_wr, in, 1, one-cycle byte strobe
- sdram_ack, in, 1, SDRAM accepted the current write
- prog_addr, out, 22, SDRAM word address
- prog_data, out, 8, byte to write
- prog_mask, out, 2, active-low byte enable
- prog_we, out, 1, write request
- prom_we, out, 4, one-hot PROM write strobe
- prom_addr, out, 8, PROM byte address
- prom_data, out, 8, PROM byte
- dwnld_busy, out, 1, loader still active
- overflow, out, 1, sticky: a byte was dropped
- checksum, out, 16, running sum of accepted bytes

Function
REQ-003 Each ioctl_wr with downloading=1 SHALL be accepted; strobes with downloading=0 SHALL be ignored.
REQ-004 Bytes with ioctl_addr < PROM_START SHALL be pushed into a 4-entry FIFO holding {prog_addr, prog_data, prog_mask}.
REQ-005 prog_addr SHALL be ioctl_addr[22:1], with region offsets applied so that the SDRAM layout is contiguous from word 0.
REQ-006 prog_mask SHALL be 2'b01 for an odd byte address (upper byte written) and 2'b10 for an even byte address.
REQ-007 Bytes in [PROM_START, PROM_START+1023] SHALL set prom_we[ioctl_addr[9:8]] for exactly one cycle, registered one cycle after ioctl_wr, with prom_addr=ioctl_addr[7:0] and prom_data=ioctl_data.
REQ-008 Bytes beyond PROM_START+1023 SHALL be discarded silently.
REQ-009 The write FSM SHALL have two states: IDLE and WAIT.
- In IDLE with the FIFO non-empty, the FSM SHALL pop the head to the prog_* outputs, set prog_we=1 on the next edge and enter WAIT.
- In WAIT, prog_we and the prog_* outputs SHALL remain stable until sdram_ack=1. On that edge prog_we SHALL go to 0 and the FSM SHALL return to IDLE.
- The minimum spacing between requests SHALL be 1 idle cycle.
REQ-010 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-011 A push to a full FIFO without a simultaneous pop SHALL drop the byte and set overflow=1; overflow SHALL clear only on reset.
REQ-012 checksum SHALL add ioctl_data for every accepted byte (SDRAM or PROM), wrap modulo 2^16, and clear on the rising edge of downloading.
REQ-013 dwnld_busy SHALL equal downloading OR FIFO non-empty OR state==WAIT.
REQ-014 If downloading falls mid-transfer, queued bytes SHALL still be written.

Reset
REQ-015 On rst_n=0, asynchronously:
- state SHALL be IDLE and the FIFO empty.
- prog_we, prom_we, overflow, checksum and dwnld_busy SHALL be 0.
- prog_addr, prog_data and prom_addr SHALL be 0, and prog_mask SHALL be 2'b11.
REQ-016 Reset asserted during WAIT SHALL abandon the transfer with no further prog_we.

Structure
REQ-017 The region start constants and the FSM state encoding SHALL reside in the shared package jtcontra_pkg.
REQ-018 The FIFO SHALL be a sub-module, jtcontra_loader_fifo (parameterised depth and width, with full/empty outputs).

Verification
REQ-019 Write ioctl_addr=0x00003, data=0x5A, with sdram_ack 3 cycles later -> prog_addr=1, prog_mask=2'b01 and prog_data=0x5A held 3 cycles, then prog_we=0.
REQ-020 Write ioctl_addr=0x128105, data=0x77 -> prom_we=4'b0010, prom_addr=0x05 and prom_data=0x77 for one cycle, with no prog_we.
REQ-021 Hold sdram_ack=0 and send 5 bytes -> 4 queued and overflow=1; then pulse sdram_ack 4 times -> 4 writes and dwnld_busy falls.
REQ-022 Send bytes 0xFF and 0x02 -> checksum=0x0101; raise downloading again -> checksum=0.
REQ-023 Drop downloading with 3 bytes queued -> all 3 written, and dwnld_busy=0 only after the last ack.
REQ-024 Assert rst_n=0 in WAIT -> prog_we=0 immediately, FIFO empty, and no write after release.
